// File: rtl/game_sched_pkg.sv
// Shared types, phase codes and the speed-scaled terminal value helper for game_step_scheduler.
package game_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_MOVE,
    ST_CHECK,
    ST_DRAW,
    ST_PAUSED,
    ST_OVER
  } sched_state_t;

  localparam logic [1:0] PHASE_MOVE  = 2'd0;
  localparam logic [1:0] PHASE_CHECK = 2'd1;
  localparam logic [1:0] PHASE_DRAW  = 2'd2;

  // Widest prescaler the helper supports; callers cast the result to their own width.
  localparam int EFF_MAX_W = 16;

  function automatic logic [EFF_MAX_W-1:0] eff_max_calc(
    input logic [EFF_MAX_W-1:0] base_max,
    input logic [2:0]           speed
  );
    logic [EFF_MAX_W-1:0] shifted;
    shifted = base_max >> speed;
    return (shifted == '0) ? EFF_MAX_W'(1) : shifted;
  endfunction

endpackage

// File: rtl/game_step_scheduler_tick_prescaler.sv
// Wrap counter with enable, clear and terminal compare; tick is high while count >= term.
module tick_prescaler #(
  parameter int PRESCALE_W = 10
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] term,
  output logic [PRESCALE_W-1:0] count,
  output logic                  tick
);

  // >= rather than == so a terminal value that drops below count still wraps.
  assign tick = (count >= term);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/game_step_scheduler.sv
// Per-tick MOVE/CHECK/DRAW sequencer with run, pause and game-over control.
// Optional ack watchdog enabled by defining SCHED_ACK_TIMEOUT_EN.
module game_step_scheduler
  import game_sched_pkg::*;
#(
  parameter int PRESCALE_W  = 10,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause_toggle,
  input  logic [2:0]            speed,
  input  logic [PRESCALE_W-1:0] base_max,
  input  logic                  phase_ack,
  input  logic                  collide,
  output logic                  phase_req,
  output logic [1:0]            phase_sel,
  output logic                  running,
  output logic                  game_over,
  output logic [PRESCALE_W-1:0] tick_count,
  output logic [PRESCALE_W-1:0] step_count,
  output logic                  timeout_err
);

  sched_state_t          state, state_n;
  logic                  pause_pending, pause_pending_n;
  logic [PRESCALE_W-1:0] eff_max;
  logic                  tick;
  logic                  tick_en;
  logic                  tick_clr;
  logic                  game_clr;
  logic                  step_inc;
  logic                  want_pause;
  logic                  timeout_hit;

  assign eff_max = PRESCALE_W'(eff_max_calc(EFF_MAX_W'(base_max), speed));

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clock  (clock),
    .clear  (reset | tick_clr),
    .enable (tick_en),
    .term   (eff_max),
    .count  (tick_count),
    .tick   (tick)
  );

`ifdef SCHED_ACK_TIMEOUT_EN
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Fires on the edge that would bring the unacknowledged wait up to ACK_TIMEOUT.
  assign timeout_hit = phase_req && !phase_ack && (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if (phase_req && !phase_ack) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (game_clr) begin
        timeout_err <= 1'b0;
      end else if (timeout_hit && state_n == ST_OVER) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A pending pause from the phase sequence and a fresh toggle cancel each other.
  assign want_pause = pause_pending ^ pause_toggle;

  always_comb begin
    state_n         = state;
    pause_pending_n = pause_pending;
    tick_en         = 1'b0;
    tick_clr        = 1'b0;
    game_clr        = 1'b0;
    step_inc        = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        pause_pending_n = 1'b0;
        if (start) begin
          state_n  = ST_WAIT_TICK;
          tick_clr = 1'b1;
          game_clr = 1'b1;
        end
      end
      ST_WAIT_TICK: begin
        if (tick) begin
          tick_en         = 1'b1;
          state_n         = ST_MOVE;
          pause_pending_n = want_pause;
        end else if (want_pause) begin
          state_n         = ST_PAUSED;
          pause_pending_n = 1'b0;
        end else begin
          tick_en = 1'b1;
        end
      end
      ST_PAUSED: begin
        pause_pending_n = 1'b0;
        if (pause_toggle) begin
          state_n = ST_WAIT_TICK;
        end
      end
      ST_MOVE, ST_CHECK, ST_DRAW: begin
        if (pause_toggle) begin
          pause_pending_n = ~pause_pending;
        end
        if (phase_ack) begin
          case (state)
            ST_MOVE:  state_n = ST_CHECK;
            ST_CHECK: state_n = collide ? ST_OVER : ST_DRAW;
            default: begin
              state_n  = ST_WAIT_TICK;
              step_inc = 1'b1;
            end
          endcase
        end else if (timeout_hit) begin
          state_n = ST_OVER;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      pause_pending <= 1'b0;
      step_count    <= '0;
      phase_req     <= 1'b0;
      phase_sel     <= PHASE_MOVE;
      running       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_n;
      pause_pending <= pause_pending_n;
      if (game_clr) begin
        step_count <= '0;
      end else if (step_inc) begin
        step_count <= step_count + PRESCALE_W'(1);
      end
      // Outputs are decoded from the next state so they line up with the registered state.
      phase_req <= (state_n == ST_MOVE) || (state_n == ST_CHECK) || (state_n == ST_DRAW);
      case (state_n)
        ST_CHECK: phase_sel <= PHASE_CHECK;
        ST_DRAW:  phase_sel <= PHASE_DRAW;
        default:  phase_sel <= PHASE_MOVE;
      endcase
      running   <= (state_n == ST_WAIT_TICK) || (state_n == ST_MOVE) ||
                   (state_n == ST_CHECK) || (state_n == ST_DRAW);
      game_over <= (state_n == ST_OVER);
    end
  end

endmodule

// File: tb/tb_game_step_scheduler.sv
// Directed bench for game_step_scheduler; expected values are hand-derived cycle counts.
module tb_game_step_scheduler;

  localparam int PW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause_toggle = 1'b0;
  logic [2:0]    speed = 3'd0;
  logic [PW-1:0] base_max = PW'(4);
  logic          phase_ack = 1'b0;
  logic          collide = 1'b0;
  logic          phase_req;
  logic [1:0]    phase_sel;
  logic          running;
  logic          game_over;
  logic [PW-1:0] tick_count;
  logic [PW-1:0] step_count;
  logic          timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int edges;

  game_step_scheduler #(
    .PRESCALE_W  (PW),
    .ACK_TIMEOUT (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pause_toggle (pause_toggle),
    .speed        (speed),
    .base_max     (base_max),
    .phase_ack    (phase_ack),
    .collide      (collide),
    .phase_req    (phase_req),
    .phase_sel    (phase_sel),
    .running      (running),
    .game_over    (game_over),
    .tick_count   (tick_count),
    .step_count   (step_count),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!phase_req && n < 3000) begin
      step();
      n++;
    end
    if (!phase_req) n = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_req", phase_req, 0);
    chk("rst_sel", phase_sel, 0);
    chk("rst_running", running, 0);
    chk("rst_over", game_over, 0);
    chk("rst_tick", tick_count, 0);
    chk("rst_steps", step_count, 0);
    chk("rst_terr", timeout_err, 0);

    // Basic step: eff_max=4, ack always high; a pause in IDLE must be dropped.
    phase_ack = 1'b1;
    pulse_pause();
    chk("idle_pause_ignored", running, 0);
    pulse_start();
    chk("start_running", running, 1);
    chk("start_tick0", tick_count, 0);
    wait_req(edges);
    chk("lat_eff4", edges, 5);
    chk("sel_move", phase_sel, 0);
    step();
    chk("sel_check", phase_sel, 1);
    chk("req_held", phase_req, 1);
    step();
    chk("sel_draw", phase_sel, 2);
    step();
    chk("draw_done_req", phase_req, 0);
    chk("draw_done_steps", step_count, 1);
    chk("draw_done_tick", tick_count, 0);

    // eff_max = 40 >> 3 = 5, and base_max=0 forced to 1.
    do_reset();
    base_max = PW'(40); speed = 3'd3;
    pulse_start();
    wait_req(edges);
    chk("lat_eff5", edges, 6);
    do_reset();
    base_max = PW'(0); speed = 3'd0;
    pulse_start();
    wait_req(edges);
    chk("lat_eff1", edges, 2);

    // start during WAIT_TICK is ignored; count keeps running.
    do_reset();
    base_max = PW'(10);
    pulse_start();
    step(2);
    pulse_start();
    chk("start_ignored_tick", tick_count, 3);

    // Pause at tick_count=2, hold 20 cycles, resume and tick at eff_max=10.
    do_reset();
    pulse_start();
    step(2);
    chk("pre_pause_tick", tick_count, 2);
    pulse_pause();
    chk("paused_running", running, 0);
    step(20);
    chk("paused_tick_hold", tick_count, 2);
    chk("paused_req", phase_req, 0);
    pulse_pause();
    chk("resume_running", running, 1);
    chk("resume_tick", tick_count, 2);
    wait_req(edges);
    chk("resume_lat", edges, 9);

    // Pause during CHECK completes the step, then pauses.
    do_reset();
    base_max = PW'(4);
    pulse_start();
    wait_req(edges);
    step();
    chk("pp_sel_check", phase_sel, 1);
    pulse_pause();
    chk("pp_sel_draw", phase_sel, 2);
    step();
    chk("pp_steps", step_count, 1);
    chk("pp_wait_running", running, 1);
    step();
    chk("pp_paused_running", running, 0);
    chk("pp_paused_req", phase_req, 0);
    chk("pp_paused_tick", tick_count, 0);
    step(5);
    chk("pp_still_paused", running, 0);

    // Collision on the second step.
    do_reset();
    pulse_start();
    wait_req(edges);
    step(3);
    chk("col_first_step", step_count, 1);
    collide = 1'b1;
    wait_req(edges);
    chk("col_lat", edges, 5);
    step(2);
    chk("col_over", game_over, 1);
    chk("col_running", running, 0);
    chk("col_steps", step_count, 1);
    chk("col_req", phase_req, 0);
    collide = 1'b0;
    pulse_start();
    chk("restart_over", game_over, 0);
    chk("restart_steps", step_count, 0);
    chk("restart_running", running, 1);

    // Ack held low in MOVE.
    do_reset();
    pulse_start();
    wait_req(edges);
    step(3);
    phase_ack = 1'b0;
    wait_req(edges);
    chk("noack_lat", edges, 5);
`ifdef SCHED_ACK_TIMEOUT_EN
    step(7);
    chk("to_req_cycle8", phase_req, 1);
    step();
    chk("to_over", game_over, 1);
    chk("to_err", timeout_err, 1);
    chk("to_req_drop", phase_req, 0);
    pulse_start();
    chk("to_err_cleared", timeout_err, 0);
    wait_req(edges);
    chk("to_restart_lat", edges, 5);
`else
    step(1000);
    chk("noto_req", phase_req, 1);
    chk("noto_sel", phase_sel, 0);
    chk("noto_err", timeout_err, 0);
    chk("noto_steps", step_count, 1);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_req", phase_req, 0);
    chk("midrst_steps", step_count, 0);
    chk("midrst_running", running, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_step_scheduler.md
# game_step_scheduler

Sequences one snake-game step per programmable tick. An internal 10-bit prescaler sets the tick period. On each tick the block issues the MOVE, CHECK and DRAW phases to the game datapath over a req/ack handshake. It sits between the debounced button logic and the snake update datapath and owns run, pause and game-over control.

## Interface
- PRESCALE_W, 10: width of the prescaler, base_max and step_count.
- ACK_TIMEOUT, 255: cycles phase_req may stay unacknowledged before a fault. Used only with SCHED_ACK_TIMEOUT_EN.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a game from IDLE or OVER.
- pause_toggle  in  1  single-cycle pulse (already debounced); toggles pause.
- speed  in  3  speed level 0..7.
- base_max  in  PRESCALE_W  prescaler terminal value at speed 0.
- phase_ack  in  1  datapath accepts the current phase.
- collide  in  1  collision result; qualified by phase_ack in CHECK.
- phase_req  out  1  phase request to the datapath.
- phase_sel  out  2  0=MOVE, 1=CHECK, 2=DRAW; 3 is never driven.
- running  out  1  high in WAIT_TICK, MOVE, CHECK and DRAW.
- game_over  out  1  high in OVER.
- tick_count  out  PRESCALE_W  current prescaler value.
- step_count  out  PRESCALE_W  number of completed steps; wraps from 1023 to 0.
- timeout_err  out  1  sticky ack-timeout fault; tied 0 without the macro.

## Operation
- States: IDLE, WAIT_TICK, MOVE, CHECK, DRAW, PAUSED, OVER. Reset enters IDLE and clears every output and counter to 0.
- Effective terminal value: eff_max = base_max >> speed, forced to 1 if the result is 0. It is recomputed every cycle.
- IDLE/OVER:
  - start goes to WAIT_TICK and clears tick_count, step_count, game_over and timeout_err.
  - pause_toggle is ignored in these states and clears any pending pause.
  - start and pause_toggle in the same cycle: start wins, pause is dropped.
- WAIT_TICK:
  - tick_count increments each cycle.
  - When tick_count >= eff_max: tick_count goes to 0 and the state goes to MOVE. Using >= means a speed increase never stalls the prescaler.
  - pause_toggle goes to PAUSED instead; the tick has priority if both occur in the same cycle, and the pause becomes pending.
- PAUSED:
  - tick_count is frozen.
  - pause_toggle returns to WAIT_TICK with the count preserved.
- Phase states (MOVE, CHECK, DRAW):
  - phase_req=1 and phase_sel holds the phase code. The request holds until phase_ack.
  - phase_ack acknowledges the phase shown on phase_sel in the same cycle. phase_ack while phase_req=0 is ignored.
  - MOVE+ack goes to CHECK.
  - CHECK+ack+collide goes to OVER.
  - CHECK+ack with collide=0 goes to DRAW.
  - DRAW+ack goes to WAIT_TICK and increments step_count.
- A pause_toggle during a phase state sets a pending flag. The pending pause is taken on arrival in WAIT_TICK, which then goes to PAUSED on the next cycle. A second toggle during the same phase sequence cancels the pending flag.
- start during WAIT_TICK, PAUSED or a phase state is ignored.

## Timing
- All outputs are registered and reflect the current state.
- If start is sampled at edge 0:
  - WAIT_TICK with tick_count=0 from cycle 1.
  - The tick condition occurs in cycle eff_max+1.
  - phase_req rises in cycle eff_max+2.
- Tick period with zero-wait acks is eff_max+1 cycles in WAIT_TICK plus 3 phase cycles.
- Each ack advances the state exactly one edge later. phase_req stays high across MOVE→CHECK→DRAW; only phase_sel changes.
- Reset mid-phase drops phase_req in the next cycle with no completion, and step_count clears.

## Configuration
- SCHED_ACK_TIMEOUT_EN defined:
  - A wait counter clears on each phase entry and increments while phase_req=1 without ack.
  - When it reaches ACK_TIMEOUT, the state goes to OVER and timeout_err is set. timeout_err stays set until start or reset.
- SCHED_ACK_TIMEOUT_EN undefined: phases wait indefinitely, there is no wait counter, and timeout_err is constant 0.

## Structure
- Package game_sched_pkg holds:
  - the state enum;
  - phase codes PHASE_MOVE=2'd0, PHASE_CHECK=2'd1, PHASE_DRAW=2'd2;
  - the eff_max helper function.
- Sub-module tick_prescaler: a PRESCALE_W wrap counter with enable, clear and terminal-value compare. It outputs count and tick.

## Test plan
- Reset, then start with base_max=4, speed=0 and an always-high ack → phase_req first high 6 cycles after start; phase_sel sequence 0,1,2; step_count=1 after DRAW.
- base_max=40, speed=3 → eff_max=5. With base_max=0 → eff_max=1 and a 2-cycle WAIT_TICK.
- pause_toggle at tick_count=2 → tick_count holds at 2 for 20 cycles; the second toggle resumes, and the tick fires when tick_count reaches eff_max.
- pause_toggle during CHECK → the phases complete, step_count increments, then the block goes to PAUSED.
- CHECK ack with collide=1 → game_over=1, running=0, step_count unchanged. A later start clears game_over and step_count.
- With macro, ACK_TIMEOUT=8 and ack held low in MOVE → OVER and timeout_err=1 after 8 cycles of phase_req. Without macro → phase_req is still high at cycle 1000.
